fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
Time-shares one fir_filter instance between N_CH independent 16-bit sample sources. Grants one channel at a time for a burst of up to BURST samples, round-robin. Before granting the next channel, it flushes the filter history with TAPS zero samples so no channel's data leaks into another's output. Filter outputs are tagged with the originating channel and delivered with a valid strobe; outputs from flush samples are suppressed.

Parameters:
N_CH, 4, number of requesting channels (≥2)
BURST, 16, max samples accepted per grant
TAPS, 8, zero samples injected per flush (= filter tap count)
IDLE_TO, 4, consecutive cycles without handshake in STREAM that end the burst early
FIR_LAT, 1, clocks from fir_in_valid sampled high to matching fir_out valid (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
ch_valid  in  N_CH  per-channel sample valid
ch_data  in  16*N_CH  signed samples; channel i at [16*i+15:16*i]
ch_ready  out  N_CH  per-channel accept; at most one bit high
fir_in_valid  out  1  registered sample strobe to filter
fir_in  out  16  registered signed sample to filter
fir_out  in  32  signed filter result
out_valid  out  1  tagged result valid
out_data  out  32  = fir_out, passed through combinationally
out_ch  out  CW  channel index of out_data; CW = max(1, $clog2(N_CH))
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (async): state IDLE, rr_ptr 0, grant 0, counters 0, fir_in_valid 0, fir_in 0, ch_ready 0, delay line cleared (out_valid 0, out_ch 0). Reset mid-burst or mid-flush aborts immediately. No stale out_valid appears after reset release.
- Handshake: transfer on channel i when ch_valid[i] && ch_ready[i] at a rising edge. ch_ready is combinational from state/grant only, never from ch_valid.
- IDLE: ch_ready = 0, fir_in_valid = 0.
  - Scan ch_valid starting at rr_ptr, wrapping modulo N_CH.
  - On the first hit: grant ← index, burst_cnt ← 0, idle_cnt ← 0, go to STREAM.
  - With no request, remain in IDLE.
- STREAM: ch_ready[grant] = 1.
  - On handshake: fir_in ← sample, fir_in_valid ← 1, tag ← {data, grant}, burst_cnt++, idle_cnt ← 0. Otherwise fir_in_valid ← 0 and idle_cnt++.
  - Go to FLUSH on the handshake that makes burst_cnt = BURST, or when idle_cnt reaches IDLE_TO. The handshake and the transition occur in the same cycle.
  - The burst may end with zero samples transferred if the channel drops valid right after grant.
- FLUSH: ch_ready = 0.
  - Each cycle: fir_in ← 0, fir_in_valid ← 1, tag ← {flush, grant}.
  - After exactly TAPS flush cycles: rr_ptr ← (grant+1) mod N_CH, go to IDLE.
  - A flush always runs, even after a zero-sample burst.
- Delay line: FIR_LAT stages of {valid = fir_in_valid && !flush, ch}, shifted every cycle. The final stage drives out_valid and out_ch. out_data = fir_out.
- Latency: handshake at edge k → fir_in_valid high after edge k → out_valid high after edge k+FIR_LAT.
- Simultaneous requests: lowest index at or after rr_ptr wins. A channel requesting during another's grant waits and is never dropped.
- Minimum turnaround between bursts: TAPS flush cycles plus 1 IDLE arbitration cycle.
- Counter widths: $clog2 of the largest of BURST, TAPS and IDLE_TO, plus 1.

Decomposition:
- Shared package fir_sched_pkg:
  - state enum {IDLE, STREAM, FLUSH}
  - SAMPLE_W = 16, ACC_W = 32
  - function clog2_min1
- Sub-module fir_tag_delay: parameterised FIR_LAT-deep shift register of {valid, ch}, async reset. Reused wherever the team tags pipelined filter output.

Test Plan:
(Bench uses N_CH=4, BURST=4, TAPS=8, IDLE_TO=3, FIR_LAT=1, real fir_filter attached.)
1. Single channel: ch1 holds valid with samples 10,20,30,40,50 → ch1 accepts 4 samples; FLUSH lasts 8 cycles with fir_in=0; ch1 is re-granted for sample 50. out_ch=1 on exactly 5 out_valid pulses, each 1 cycle after its fir_in_valid.
2. Round-robin: all four channels valid continuously → grant order 0,1,2,3,0. No two ch_ready bits are ever high together. Each burst is 4 samples.
3. Isolation: ch0 sends 1000×4, then ch2 sends 0×4 → ch2's 4 outputs are all 0, proving the flush cleared ch0 history.
4. Idle timeout: ch3 sends 2 samples, then drops valid → after 3 idle cycles the block enters FLUSH. Exactly 2 out_valid pulses tagged 3; rr_ptr becomes 0.
5. Reset mid-flush: assert reset at flush cycle 4 → outputs go to reset values immediately. After release, the block sits in IDLE with no out_valid, then grants ch0 first.
6. Backpressure-free corner: ch0 valid for one cycle just after grant, then low → zero-sample burst still runs an 8-cycle flush. No out_valid is produced.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared types and helpers for the FIR channel scheduler
package fir_sched_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fir_tag_delay.sv
// rtl/fir_tag_delay.sv - LAT-deep {valid, ch} tag pipeline aligned to filter latency
module fir_tag_delay #(
  parameter int LAT = 1,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  output logic          out_valid,
  output logic [CW-1:0] out_ch
);

  logic [LAT-1:0] v_q;
  logic [CW-1:0]  ch_q [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) ch_q[i] <= '0;
    end else begin
      v_q[0]  <= in_valid;
      ch_q[0] <= in_ch;
      for (int i = 1; i < LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        ch_q[i] <= ch_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_ch    = ch_q[LAT-1];

endmodule

// File: rtl/fir_channel_scheduler.sv
// rtl/fir_channel_scheduler.sv - round-robin time-sharing of one FIR filter across channels
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int  N_CH    = 4,
  parameter int  BURST   = 16,
  parameter int  TAPS    = 8,
  parameter int  IDLE_TO = 4,
  parameter int  FIR_LAT = 1,
  localparam int CW      = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [SAMPLE_W*N_CH-1:0] ch_data,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     fir_in_valid,
  output logic [SAMPLE_W-1:0]      fir_in,
  input  logic [ACC_W-1:0]         fir_out,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_data,
  output logic [CW-1:0]            out_ch,
  output logic                     busy
);

  localparam int CNT_W = $clog2(max3(BURST, TAPS, IDLE_TO)) + 1;

  state_t              state, state_d;
  logic [CW-1:0]       grant, grant_d;
  logic [CW-1:0]       rr_ptr, rr_d;
  logic [CNT_W-1:0]    burst_cnt, burst_d;
  logic [CNT_W-1:0]    idle_cnt, idle_d;
  logic [CNT_W-1:0]    flush_cnt, flush_d;
  logic                fiv_d;
  logic [SAMPLE_W-1:0] fin_d;
  logic                tag_flush, tag_flush_d;
  logic [CW-1:0]       tag_ch, tag_ch_d;
  logic                req_found;
  logic [CW-1:0]       req_pick;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_pick  = rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!req_found && ch_valid[(int'(rr_ptr) + k) % N_CH]) begin
        req_found = 1'b1;
        req_pick  = CW'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    rr_d        = rr_ptr;
    burst_d     = burst_cnt;
    idle_d      = idle_cnt;
    flush_d     = flush_cnt;
    fiv_d       = 1'b0;
    fin_d       = fir_in;
    tag_flush_d = tag_flush;
    tag_ch_d    = tag_ch;
    ch_ready    = '0;
    case (state)
      IDLE: begin
        if (req_found) begin
          grant_d = req_pick;
          burst_d = '0;
          idle_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        ch_ready[grant] = 1'b1;
        if (ch_valid[grant]) begin
          fin_d       = ch_data[SAMPLE_W*grant +: SAMPLE_W];
          fiv_d       = 1'b1;
          tag_flush_d = 1'b0;
          tag_ch_d    = grant;
          burst_d     = burst_cnt + 1'b1;
          idle_d      = '0;
          if (burst_cnt == CNT_W'(BURST - 1)) begin
            flush_d = '0;
            state_d = FLUSH;
          end
        end else begin
          idle_d = idle_cnt + 1'b1;
          if (idle_cnt == CNT_W'(IDLE_TO - 1)) begin
            flush_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Zeros push the previous channel's history out of every tap.
        fin_d       = '0;
        fiv_d       = 1'b1;
        tag_flush_d = 1'b1;
        tag_ch_d    = grant;
        flush_d     = flush_cnt + 1'b1;
        if (flush_cnt == CNT_W'(TAPS - 1)) begin
          rr_d    = (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      idle_cnt     <= '0;
      flush_cnt    <= '0;
      fir_in_valid <= 1'b0;
      fir_in       <= '0;
      tag_flush    <= 1'b0;
      tag_ch       <= '0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      rr_ptr       <= rr_d;
      burst_cnt    <= burst_d;
      idle_cnt     <= idle_d;
      flush_cnt    <= flush_d;
      fir_in_valid <= fiv_d;
      fir_in       <= fin_d;
      tag_flush    <= tag_flush_d;
      tag_ch       <= tag_ch_d;
    end
  end

  fir_tag_delay #(
    .LAT (FIR_LAT),
    .CW  (CW)
  ) u_tag_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fir_in_valid && !tag_flush),
    .in_ch     (tag_ch),
    .out_valid (out_valid),
    .out_ch    (out_ch)
  );

  assign out_data = fir_out;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb/tb_fir_channel_scheduler.sv - self-checking bench with 8-tap filter and behavioural model
module tb_fir_channel_scheduler;

  localparam int NC = 4, BU = 4, TP = 8, ITO = 3, LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_valid = '0;
  logic [63:0] ch_data = '0;
  logic [3:0]  ch_ready;
  logic        fir_in_valid;
  logic [15:0] fir_in;
  logic [31:0] fir_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        busy;

  fir_channel_scheduler #(
    .N_CH(NC), .BURST(BU), .TAPS(TP), .IDLE_TO(ITO), .FIR_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .fir_in_valid(fir_in_valid), .fir_in(fir_in),
    .fir_out(fir_out), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // 8-tap filter, coefficients 1..8, one clock of latency
  logic signed [15:0] f_hist [8];
  int f_acc;
  always_comb begin
    f_acc = int'($signed(fir_in));
    for (int i = 1; i < 8; i++) f_acc += (i + 1) * int'(f_hist[i-1]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fir_out <= '0;
      for (int i = 0; i < 8; i++) f_hist[i] <= '0;
    end else if (fir_in_valid) begin
      fir_out   <= f_acc;
      f_hist[0] <= $signed(fir_in);
      for (int i = 1; i < 8; i++) f_hist[i] <= f_hist[i-1];
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  // Sources: per-channel sample queues, presented while enabled
  int src_q [4][$];
  bit src_en [4];
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        ch_valid[i] = 1'b1;
        ch_data[16*i +: 16] = 16'(src_q[i][0]);
      end else begin
        ch_valid[i] = 1'b0;
        ch_data[16*i +: 16] = '0;
      end
    end
  endtask

  // Behavioural model: phase 0 idle, 1 streaming, 2 flushing
  int m_phase, m_grant, m_rr, m_taken, m_quiet, m_flushed;
  int m_hist[$];
  int e_fiv, e_fin, e_flush, e_tch, e_pend, e_ov, e_och, e_od;

  function automatic int conv();
    int acc = 0;
    for (int j = 0; j < m_hist.size() && j < 8; j++) acc += (j + 1) * m_hist[j];
    return acc;
  endfunction

  task automatic model_step();
    int s;
    if (reset) begin
      m_phase = 0; m_grant = 0; m_rr = 0; m_taken = 0; m_quiet = 0; m_flushed = 0;
      m_hist.delete();
      e_fiv = 0; e_fin = 0; e_flush = 0; e_tch = 0; e_pend = 0; e_ov = 0; e_och = 0; e_od = 0;
      return;
    end
    e_ov = e_fiv && !e_flush;
    e_och = e_tch;
    e_od = e_pend;
    if (m_phase == 0) begin
      e_fiv = 0;
      for (int k = 0; k < NC; k++) begin
        if (m_phase == 0 && ch_valid[(m_rr + k) % NC]) begin
          m_grant = (m_rr + k) % NC;
          m_taken = 0; m_quiet = 0;
          m_hist.delete();
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (ch_valid[m_grant]) begin
        s = int'($signed(ch_data[16*m_grant +: 16]));
        m_hist.push_front(s);
        e_pend = conv();
        e_fin = s; e_fiv = 1; e_flush = 0; e_tch = m_grant;
        m_taken++; m_quiet = 0;
        if (src_q[m_grant].size() > 0) void'(src_q[m_grant].pop_front());
        if (m_taken == BU) begin m_phase = 2; m_flushed = 0; end
      end else begin
        e_fiv = 0;
        m_quiet++;
        if (m_quiet == ITO) begin m_phase = 2; m_flushed = 0; end
      end
    end else begin
      e_fin = 0; e_fiv = 1; e_flush = 1; e_tch = m_grant;
      m_flushed++;
      if (m_flushed == TP) begin m_rr = (m_grant + 1) % NC; m_phase = 0; end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  int lg_ch[$], lg_data[$], m_lg_data[$];

  initial forever begin
    @(negedge clk);
    chk("ch_ready", ch_ready, (m_phase == 1) ? (1 << m_grant) : 0);
    chk("busy", busy, m_phase != 0);
    chk("fir_in_valid", fir_in_valid, e_fiv);
    if (e_fiv) chk("fir_in", int'($signed(fir_in)), e_fin);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_ch", out_ch, e_och);
      chk("out_data", int'(out_data), e_od);
      m_lg_data.push_back(e_od);
    end
    if (out_valid) begin
      lg_ch.push_back(int'(out_ch));
      lg_data.push_back(int'(out_data));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      refresh();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_ready"}, ch_ready, 0);
    chk({tag, "_rst_fiv"}, fir_in_valid, 0);
    chk({tag, "_rst_fin"}, fir_in, 0);
    chk({tag, "_rst_ov"}, out_valid, 0);
    chk({tag, "_rst_och"}, out_ch, 0);
    chk({tag, "_rst_busy"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin src_q[i].delete(); src_en[i] = 1'b1; end
    refresh();
    #1;
    check_reset_outputs(tag);
    cycles(2);
    reset = 1'b0;
    lg_ch.delete(); lg_data.delete(); m_lg_data.delete();
  endtask

  initial begin
    int bcnt, fcnt, guard;

    // 1: single channel, burst limit then re-grant
    do_reset("t1");
    src_q[1] = '{10, 20, 30, 40, 50};
    refresh();
    cycles(35);
    chk("t1_count", lg_ch.size(), 5);
    if (lg_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t1_ch", lg_ch[i], 1);
      chk("t1_d0", lg_data[0], 10);
      chk("t1_d1", lg_data[1], 40);
      chk("t1_d2", lg_data[2], 100);
      chk("t1_d3", lg_data[3], 200);
      chk("t1_d4", lg_data[4], 50);
      chk("t1_model_d3", m_lg_data[3], 200);
    end

    // 2: all channels requesting, round-robin order 0,1,2,3,0
    do_reset("t2");
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 8; k++) src_q[c].push_back(c * 100 + k + 1);
    refresh();
    cycles(70);
    chk("t2_count_ge20", lg_ch.size() >= 20, 1);
    if (lg_ch.size() >= 20) begin
      for (int i = 0; i < 20; i++) chk("t2_order", lg_ch[i], (i / 4) % 4);
      chk("t2_d0", lg_data[0], 1);
      chk("t2_d3", lg_data[3], 20);
      chk("t2_d4", lg_data[4], 101);
      chk("t2_d16", lg_data[16], 5);
      chk("t2_model_d1", m_lg_data[1], 4);
    end

    // 3: flush isolates ch0 history from ch2
    do_reset("t3");
    src_q[0] = '{1000, 1000, 1000, 1000};
    src_q[2] = '{0, 0, 0, 0};
    refresh();
    cycles(35);
    chk("t3_count", lg_ch.size(), 8);
    if (lg_ch.size() == 8) begin
      chk("t3_d3", lg_data[3], 10000);
      for (int i = 4; i < 8; i++) begin
        chk("t3_ch2", lg_ch[i], 2);
        chk("t3_zero", lg_data[i], 0);
      end
    end

    // 4: idle timeout, then rr_ptr wraps to 0
    do_reset("t4");
    src_q[3] = '{7, 9};
    refresh();
    cycles(20);
    chk("t4_count", lg_ch.size(), 2);
    src_q[0] = '{5};
    src_q[3] = '{6};
    refresh();
    cycles(6);
    chk("t4_count2", lg_ch.size() >= 3, 1);
    if (lg_ch.size() >= 3) begin
      chk("t4_ch_a", lg_ch[0], 3);
      chk("t4_ch_b", lg_ch[1], 3);
      chk("t4_d1", lg_data[1], 23);
      chk("t4_next_ch0", lg_ch[2], 0);
      chk("t4_next_d", lg_data[2], 5);
    end

    // 5: reset during the 4th flush cycle
    do_reset("t5");
    src_q[1] = '{1, 2, 3, 4};
    refresh();
    guard = 0;
    while (m_phase != 2 && guard < 50) begin cycles(1); guard++; end
    chk("t5_flush_reached", m_phase, 2);
    cycles(3);
    chk("t5_busy_pre", busy, 1);
    chk("t5_fiv_pre", fir_in_valid, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_mid");
    for (int i = 0; i < 4; i++) src_q[i].delete();
    cycles(2);
    reset = 1'b0;
    lg_ch.delete(); lg_data.delete(); m_lg_data.delete();
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_ov", out_valid, 0);
    end
    src_q[0] = '{11};
    src_q[1] = '{22};
    refresh();
    cycles(25);
    chk("t5_count", lg_ch.size(), 2);
    if (lg_ch.size() == 2) begin
      chk("t5_first_ch0", lg_ch[0], 0);
      chk("t5_second_ch1", lg_ch[1], 1);
    end

    // 6: zero-sample burst still flushes, no outputs
    do_reset("t6");
    src_q[0] = '{99};
    refresh();
    cycles(1);
    src_en[0] = 1'b0;
    refresh();
    bcnt = int'(busy);
    fcnt = int'(fir_in_valid);
    repeat (19) begin
      cycles(1);
      bcnt += int'(busy);
      fcnt += int'(fir_in_valid);
    end
    chk("t6_busy_cycles", bcnt, 11);
    chk("t6_flush_cycles", fcnt, 8);
    chk("t6_no_out", lg_ch.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
